// File: rtl/snn_pkg.sv
// Shared definitions for the spike-encoding front end.
// Contents:
//   enc_state_e  - encoder frame states (IDLE / RUN / DONE)
//   step_cnt_w() - width of a step counter that must hold the value T_STEPS
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    // The counter reaches T_STEPS itself on the last timestep, hence +1.
    function automatic int step_cnt_w(input int t_steps);
        return (t_steps < 1) ? 1 : $clog2(t_steps + 1);
    endfunction

endpackage

// File: rtl/rate_spike_encoder_if.sv
// Host/neuron-side bundle of the rate spike encoder.
// Signals:
//   enable       host -> enc  global stall, low freezes the encoder
//   load         host -> enc  frame start request
//   intensities  host -> enc  M unsigned IW-bit intensities, channel i at [i*IW +: IW]
//   input_spikes enc -> host  spike vector of the current timestep
//   spike_valid  enc -> host  input_spikes carries a fresh timestep
//   busy         enc -> host  frame in progress (RUN or DONE)
//   frame_done   enc -> host  one-cycle pulse after the last timestep
// Modports: master = host/driver side, slave = encoder side.
interface rate_spike_encoder_if #(
    parameter int M  = 8,
    parameter int IW = 4
) ();

    logic              enable;
    logic              load;
    logic [M*IW-1:0]   intensities;
    logic [M-1:0]      input_spikes;
    logic              spike_valid;
    logic              busy;
    logic              frame_done;

    modport master (
        output enable, load, intensities,
        input  input_spikes, spike_valid, busy, frame_done
    );

    modport slave (
        input  enable, load, intensities,
        output input_spikes, spike_valid, busy, frame_done
    );

endinterface

// File: rtl/rate_acc_channel.sv
// One sigma-delta rate-coding channel.
// Holds the captured intensity and an IW-bit accumulator; every step the
// intensity is added and the carry out of the accumulator is the spike.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr_i         capture intensity_i and zero the accumulator (frame start)
//   step_en_i     consume one timestep (accumulate)
//   intensity_i   unsigned intensity to capture on clr_i
//   spike_o       spike of the step being consumed (combinational carry)
module rate_acc_channel #(
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          step_en_i,
    input  logic [IW-1:0] intensity_i,
    output logic          spike_o
);

    logic [IW-1:0] int_q, int_d;
    logic [IW-1:0] acc_q, acc_d;
    logic [IW:0]   sum;

    // Accumulator wrap is the spike event, so the carry needs no saturation.
    assign sum     = {1'b0, acc_q} + {1'b0, int_q};
    assign spike_o = sum[IW];

    always_comb begin
        int_d = int_q;
        acc_d = acc_q;
        if (clr_i) begin
            int_d = intensity_i;
            acc_d = '0;
        end else if (step_en_i) begin
            acc_d = sum[IW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= '0;
            acc_q <= '0;
        end else begin
            int_q <= int_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rate_spike_encoder.sv
// Rate spike encoder: turns M intensities into M deterministic sigma-delta
// spike trains, one spike vector per enabled cycle for T_STEPS timesteps.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active low
//   bus    rate_spike_encoder_if.slave (enable, load, intensities in;
//          input_spikes, spike_valid, busy, frame_done out)
// All outputs are registered.
module rate_spike_encoder
    import snn_pkg::*;
#(
    parameter int M       = 8,
    parameter int IW      = 4,
    parameter int T_STEPS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rate_spike_encoder_if.slave   bus
);

    localparam int            SW   = step_cnt_w(T_STEPS);
    localparam logic [SW-1:0] LAST = SW'(T_STEPS);

    enc_state_e    state_q;
    logic [SW-1:0] step_q;
    logic [SW-1:0] step_nxt;
    logic [M-1:0]  spikes_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;

    logic          accept;
    logic          step_en;
    logic [M-1:0]  ch_spike;

    assign accept   = (state_q == ST_IDLE) && bus.enable && bus.load;
    assign step_en  = (state_q == ST_RUN)  && bus.enable;
    assign step_nxt = step_q + 1'b1;

    for (genvar g = 0; g < M; g++) begin : g_ch
        rate_acc_channel #(.IW(IW)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_i       (accept),
            .step_en_i   (step_en),
            .intensity_i (bus.intensities[g*IW +: IW]),
            .spike_o     (ch_spike[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            spikes_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Spike outputs and frame_done only ever last one cycle; a stalled
            // edge therefore leaves zeros on the outputs without touching state.
            spikes_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            if (bus.enable) begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.load) begin
                            state_q <= ST_RUN;
                            step_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        spikes_q <= ch_spike;
                        valid_q  <= 1'b1;
                        step_q   <= step_nxt;
                        if (step_nxt == LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // A load seen here is dropped: the frame is not over yet.
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.input_spikes = spikes_q;
    assign bus.spike_valid  = valid_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_rate_spike_encoder.sv
module tb_rate_spike_encoder;

    localparam int M  = 8;
    localparam int IW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rate_spike_encoder_if #(.M(M), .IW(IW)) bus16 ();
    rate_spike_encoder_if #(.M(M), .IW(IW)) bus1 ();

    rate_spike_encoder #(.M(M), .IW(IW), .T_STEPS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16));
    rate_spike_encoder #(.M(M), .IW(IW), .T_STEPS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: frame phase, timestep index and captured intensities.
    // The spike of channel c at step k is the increase of floor(k*I/2^IW),
    // i.e. how many times the running total k*I crossed a multiple of 2^IW.
    int           m_st[2];
    int           m_k[2];
    int           m_I[2][M];
    int           t_of[2];
    logic [M-1:0] e_sp[2];
    logic         e_sv[2];
    logic         e_busy[2];
    logic         e_fd[2];

    logic [M-1:0] cap[$];
    logic [M-1:0] ref3[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [M*IW-1:0] pack(input int a[M]);
        logic [M*IW-1:0] v = '0;
        for (int c = 0; c < M; c++) v[c*IW +: IW] = a[c][IW-1:0];
        return v;
    endfunction

    function automatic logic [M*IW-1:0] fill(input int x);
        logic [M*IW-1:0] v = '0;
        for (int c = 0; c < M; c++) v[c*IW +: IW] = x[IW-1:0];
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_k[d] = 0;
            for (int c = 0; c < M; c++) m_I[d][c] = 0;
            e_sp[d] = '0; e_sv[d] = 1'b0; e_busy[d] = 1'b0; e_fd[d] = 1'b0;
        end
    endtask

    task automatic model_edge(input int d, input logic en, input logic ld,
                              input logic [M*IW-1:0] iv);
        e_fd[d] = 1'b0; e_sv[d] = 1'b0; e_sp[d] = '0;
        if (en) begin
            if (m_st[d] == 0) begin
                if (ld) begin
                    m_st[d] = 1; m_k[d] = 0; e_busy[d] = 1'b1;
                    for (int c = 0; c < M; c++) m_I[d][c] = int'(iv[c*IW +: IW]);
                end
            end else if (m_st[d] == 1) begin
                m_k[d]++;
                e_sv[d] = 1'b1;
                for (int c = 0; c < M; c++)
                    e_sp[d][c] = ((m_k[d] * m_I[d][c]) >> IW) != (((m_k[d] - 1) * m_I[d][c]) >> IW);
                if (m_k[d] == t_of[d]) m_st[d] = 2;
            end else begin
                e_fd[d] = 1'b1; e_busy[d] = 1'b0; m_st[d] = 0;
            end
        end
    endtask

    initial begin
        t_of[0] = 16;
        t_of[1] = 1;
        model_reset();
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_edge(0, bus16.enable, bus16.load, bus16.intensities);
            model_edge(1, bus1.enable, bus1.load, bus1.intensities);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("spikes16", 64'(bus16.input_spikes), 64'(e_sp[0]));
        chk("valid16",  64'(bus16.spike_valid),  64'(e_sv[0]));
        chk("busy16",   64'(bus16.busy),         64'(e_busy[0]));
        chk("done16",   64'(bus16.frame_done),   64'(e_fd[0]));
        chk("spikes1",  64'(bus1.input_spikes),  64'(e_sp[1]));
        chk("valid1",   64'(bus1.spike_valid),   64'(e_sv[1]));
        chk("busy1",    64'(bus1.busy),          64'(e_busy[1]));
        chk("done1",    64'(bus1.frame_done),    64'(e_fd[1]));
        if (bus16.spike_valid) cap.push_back(bus16.input_spikes);
    end

    task automatic wait_done16(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus16.frame_done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic load16(input logic [M*IW-1:0] iv);
        @(negedge clk);
        bus16.intensities = iv;
        bus16.load = 1'b1;
        @(negedge clk);
        bus16.load = 1'b0;
    endtask

    function automatic int ch_total(input int c);
        int n = 0;
        foreach (cap[j]) n += int'(cap[j][c]);
        return n;
    endfunction

    function automatic int ch_pattern(input int c);
        int p = 0;
        foreach (cap[j]) if (cap[j][c]) p |= (1 << j);
        return p;
    endfunction

    int mix[M] = '{0, 1, 8, 15, 4, 2, 3, 5};

    initial begin
        int ones;
        int bcnt, vcnt, fcnt;
        logic [M-1:0] vor;

        bus16.enable = 1'b0; bus16.load = 1'b0; bus16.intensities = '0;
        bus1.enable  = 1'b1; bus1.load  = 1'b0; bus1.intensities  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_spikes", 64'(bus16.input_spikes), 64'd0);
        chk("rst_valid",  64'(bus16.spike_valid),  64'd0);
        chk("rst_busy",   64'(bus16.busy),         64'd0);
        rst_n = 1'b1;
        bus16.enable = 1'b1;
        repeat (2) @(negedge clk);

        // All intensities 15: step 1 silent, steps 2..16 all ones
        cap.delete();
        load16(fill(15));
        wait_done16("all15");
        chk("all15_len", 64'(cap.size()), 64'd16);
        chk("all15_step1", 64'(cap[0]), 64'd0);
        ones = 0;
        for (int j = 1; j < cap.size(); j++) if (cap[j] == 8'hFF) ones++;
        chk("all15_ones", 64'(ones), 64'd15);
        @(negedge clk);
        chk("all15_done_pulse", 64'(bus16.frame_done), 64'd0);

        // Mixed intensities
        cap.delete();
        load16(pack(mix));
        bus16.intensities = fill(9);
        wait_done16("mix");
        chk("mix_len", 64'(cap.size()), 64'd16);
        for (int c = 0; c < M; c++) chk($sformatf("mix_total_ch%0d", c), 64'(ch_total(c)), 64'(mix[c]));
        chk("mix_ch2_steps", 64'(ch_pattern(2)), 64'hAAAA);
        chk("mix_ch1_steps", 64'(ch_pattern(1)), 64'h8000);
        ref3 = cap;

        // Stall: enable toggles every cycle during the frame
        repeat (2) @(negedge clk);
        cap.delete();
        load16(pack(mix));
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                bus16.enable = ~bus16.enable;
                @(negedge clk);
                if (bus16.frame_done) seen = 1'b1;
            end
            chk("stall_done_seen", 64'(seen), 64'd1);
        end
        bus16.enable = 1'b1;
        chk("stall_len", 64'(cap.size()), 64'd16);
        for (int j = 0; j < 16 && j < cap.size(); j++)
            chk($sformatf("stall_vec%0d", j), 64'(cap[j]), 64'(ref3[j]));

        // load while busy and coincident with the DONE->IDLE edge is dropped
        repeat (2) @(negedge clk);
        cap.delete();
        load16(pack(mix));
        for (int i = 0; i < 50 && cap.size() < 4; i++) @(negedge clk);
        bus16.intensities = fill(15);
        bus16.load = 1'b1;
        @(negedge clk);
        bus16.load = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (m_st[0] == 2) seen = 1'b1;
            end
            chk("late_done_state_seen", 64'(seen), 64'd1);
        end
        bus16.intensities = fill(7);
        bus16.load = 1'b1;
        @(negedge clk);
        chk("late_frame_done", 64'(bus16.frame_done), 64'd1);
        bus16.load = 1'b0;
        for (int j = 0; j < 16 && j < cap.size(); j++)
            chk($sformatf("late_vec%0d", j), 64'(cap[j]), 64'(ref3[j]));
        repeat (3) @(negedge clk);
        chk("late_no_restart", 64'(bus16.busy), 64'd0);
        cap.delete();
        load16(fill(7));
        wait_done16("i7");
        for (int c = 0; c < M; c++) chk($sformatf("i7_total_ch%0d", c), 64'(ch_total(c)), 64'd7);

        // T_STEPS=1 instance
        @(negedge clk);
        bus1.intensities = fill(15);
        bus1.load = 1'b1;
        bcnt = 0; vcnt = 0; fcnt = 0; vor = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus1.load = 1'b0;
            bcnt += int'(bus1.busy);
            vcnt += int'(bus1.spike_valid);
            fcnt += int'(bus1.frame_done);
            if (bus1.spike_valid) vor |= bus1.input_spikes;
        end
        chk("t1_busy_cycles",  64'(bcnt), 64'd2);
        chk("t1_valid_cycles", 64'(vcnt), 64'd1);
        chk("t1_done_pulses",  64'(fcnt), 64'd1);
        chk("t1_vector",       64'(vor),  64'd0);

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus16.enable      = ($urandom_range(3) != 0);
            bus16.load        = ($urandom_range(7) == 0);
            bus16.intensities = M*IW'($urandom());
            bus1.enable       = ($urandom_range(3) != 0);
            bus1.load         = ($urandom_range(3) == 0);
            bus1.intensities  = M*IW'($urandom());
        end
        bus16.enable = 1'b1; bus16.load = 1'b0;
        bus1.enable  = 1'b1; bus1.load  = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-frame
        load16(fill(15));
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_spikes", 64'(bus16.input_spikes), 64'd0);
        chk("arst_valid",  64'(bus16.spike_valid),  64'd0);
        chk("arst_busy",   64'(bus16.busy),         64'd0);
        chk("arst_done",   64'(bus16.frame_done),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cap.delete();
        load16(pack(mix));
        wait_done16("post_rst");
        chk("post_rst_len", 64'(cap.size()), 64'd16);
        chk("post_rst_ch3", 64'(ch_total(3)), 64'd15);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
